alu_issue_buffer: RTL
=====================

Name: alu_issue_buffer

Overview:
Reservation buffer that sits directly upstream of the ALU issue stage. It receives decoded ALU micro-ops from dispatch and writes each one into the lowest-index free slot. It exposes all DP slots in parallel, as a per-slot valid vector plus a packed info bus, so issue can pick any ready entry out of order. The slot chosen by issue is freed by index.

Parameters:
DW, `ALU_ISSUE_INFO_DW (185 when `RB=2), width of one micro-op info record; layout owned by dispatch, opaque here
DP, 4, number of slots; power of two, >=2
CW, $clog2(DP), slot index width (derived, not overridden)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  synchronous active-high reset
alu_dispatch_push  in  1  dispatch presents a micro-op this cycle
alu_dispatch_info  in  DW  micro-op record
alu_buffer_full  out  1  all slots occupied; dispatch must not push
alu_buffer_empty  out  1  no slots occupied
alu_buffer_cnt  out  CW+1  number of occupied slots
alu_buffer_pop  in  1  issue frees one slot this cycle
alu_buffer_pop_index  in  CW  slot freed by issue
alu_buffer_malloc  out  DP  bit i = slot i occupied
alu_issue_info  out  DW*DP  slot i record at [DW*i +: DW]
flush  in  1  pipeline flush, discard all entries

Behaviour:
- State:
  - malloc[DP-1:0] register.
  - info[DP][DW] register array.
  - cnt register, or cnt derived as popcount of malloc. Either is allowed, but cnt must always equal popcount(malloc).
- Reset (RST=1 at a clock edge):
  - malloc=0, all info=0, cnt=0.
  - full=0, empty=1.
  - RST has priority over flush, push and pop.
- Outputs are driven only from registers, with no combinational input-to-output path:
  - alu_buffer_malloc = malloc; alu_issue_info = info.
  - full = &malloc; empty = ~|malloc.
- Push:
  - Accepted when push=1, full=0, flush=0, RST=0.
  - Target slot = lowest index i with malloc[i]=0, taken from the registered malloc at the start of the cycle.
  - Next cycle: malloc[i]=1, info[i]=alu_dispatch_info. The entry is visible to issue one cycle after the push.
- Pop:
  - When pop=1, flush=0, RST=0 and malloc[pop_index]=1, the next cycle has malloc[pop_index]=0.
  - info for the popped slot is retained (don't-care contents).
- Simultaneous push and pop in the same cycle:
  - Both take effect and cnt is unchanged.
  - The push target is computed without counting the slot being freed. Even if the freed slot is the lowest index, the push goes to the lowest slot that was free at the start of the cycle.
  - If the buffer was full, the push is dropped even though a pop frees a slot that cycle; dispatch sees full=1 and must hold.
- Flush:
  - Next cycle malloc=0 and cnt=0.
  - Any push or pop in the flush cycle is ignored.
  - info is not cleared.
- Illegal inputs (no state change, no hang):
  - Push while full: dropped. Simulation assertion fires.
  - Pop of an unoccupied slot: ignored. Simulation assertion fires.
  - Assertions are compiled out for synthesis.
- cnt update: next cnt = cnt + accepted_push - accepted_pop. It never wraps; it stays within 0..DP.
- Throughput: one push and one pop per cycle sustained.
- Slots are not age-ordered. Issue priority (lowest ready index) is decided downstream.

Test Plan:
- Reset and pushes:
  - Stimulus: hold RST 2 cycles, release, push records A,B,C on consecutive cycles.
  - Required: after reset malloc=0000, empty=1, cnt=0. After the pushes malloc=0111, info[0]=A, info[1]=B, info[2]=C, cnt=3.
- Fill to full:
  - Stimulus: push D (buffer becomes full), then push E while full.
  - Required: after D, malloc=1111, full=1, cnt=4. E is dropped, info unchanged, assertion fires in sim.
- Simultaneous push and pop:
  - Stimulus: malloc=1011, pop_index=1 together with push F.
  - Required: next cycle malloc=1101, info[2]=F, cnt=3.
- Pop then push refills a freed low slot:
  - Stimulus: malloc=0111, pop_index=0; next cycle push G.
  - Required: after the pop malloc=0110. After the push malloc=0111, info[0]=G.
- Flush priority:
  - Stimulus: malloc=1111, flush=1 with push H and pop index 2 in the same cycle.
  - Required: next cycle malloc=0000, cnt=0, empty=1. H is not stored.
- Reset mid-operation:
  - Stimulus: malloc=0101, cnt=2, assert RST together with push.
  - Required: next cycle malloc=0000, all info=0, cnt=0, full=0.

Source files
------------

// File: rtl/alu_issue_buffer.sv
// alu_issue_buffer: reservation slots between ALU dispatch and issue.
// Dispatch writes into the lowest free slot. Issue sees every slot in parallel
// and frees one slot by index per cycle. Slots are not age-ordered.

module alu_issue_buffer #(
    parameter int DW = 185,
    parameter int DP = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    alu_dispatch_push,
    input  logic [DW-1:0]           alu_dispatch_info,
    output logic                    alu_buffer_full,
    output logic                    alu_buffer_empty,
    output logic [$clog2(DP):0]     alu_buffer_cnt,
    input  logic                    alu_buffer_pop,
    input  logic [$clog2(DP)-1:0]   alu_buffer_pop_index,
    output logic [DP-1:0]           alu_buffer_malloc,
    output logic [DW*DP-1:0]        alu_issue_info,
    input  logic                    flush
);

    localparam int CW = $clog2(DP);

    logic [DP-1:0]   malloc_q, malloc_d;
    logic [CW:0]     cnt_q, cnt_d;
    logic [DW-1:0]   info_q [DP];

    logic            free_found;
    logic [CW-1:0]   free_idx;
    logic            push_ok;
    logic            pop_ok;
    logic [DP-1:0]   push_mask;
    logic [DP-1:0]   pop_mask;

    // Lowest free slot, taken from the registered occupancy only: a slot freed
    // this cycle is not reusable until the next cycle.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DP; i++) begin
            if (!malloc_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = CW'(i);
            end
        end
    end

    // Accept/ignore decisions and next occupancy/count.
    always_comb begin
        push_ok   = alu_dispatch_push && !alu_buffer_full && !flush;
        pop_ok    = alu_buffer_pop && !flush && malloc_q[alu_buffer_pop_index];
        push_mask = push_ok ? (DP'(1) << free_idx) : '0;
        pop_mask  = pop_ok ? (DP'(1) << alu_buffer_pop_index) : '0;
        malloc_d  = (malloc_q & ~pop_mask) | push_mask;
        cnt_d     = cnt_q + (CW+1)'(push_ok) - (CW+1)'(pop_ok);
        if (flush) begin
            malloc_d = '0;
            cnt_d    = '0;
        end
    end

    // Occupancy and count registers; reset beats flush, push and pop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            malloc_q <= '0;
            cnt_q    <= '0;
        end else begin
            malloc_q <= malloc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Record storage; flush leaves contents alone, popped slots keep stale data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DP; i++) begin
                info_q[i] <= '0;
            end
        end else if (push_ok) begin
            info_q[free_idx] <= alu_dispatch_info;
        end
    end

    assign alu_buffer_malloc = malloc_q;
    assign alu_buffer_cnt    = cnt_q;
    assign alu_buffer_full   = &malloc_q;
    assign alu_buffer_empty  = ~|malloc_q;

    for (genvar g = 0; g < DP; g++) begin : g_info_out
        assign alu_issue_info[DW*g +: DW] = info_q[g];
    end

`ifndef SYNTHESIS
    // Flag dispatch/issue protocol violations; the hardware simply ignores them.
    always_ff @(posedge CLK) begin
        if (!RST && !flush) begin
            assert (!(alu_dispatch_push && alu_buffer_full))
                else $warning("alu_issue_buffer: push while full dropped");
            assert (!(alu_buffer_pop && !malloc_q[alu_buffer_pop_index]))
                else $warning("alu_issue_buffer: pop of empty slot ignored");
        end
    end
`endif

endmodule
